// File: rtl/johnson_counter_param.sv
// rtl/johnson_counter_param.sv - parametrised Johnson counter with load, direction, self-correction and phase decode
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             valid,
    output logic             tc,
    output logic             err
);

    // Last forward phase (2*WIDTH-1): only the MSB set; a forward step from here wraps to zero.
    localparam logic [WIDTH-1:0] LAST_FWD = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-2:0] edges;
    logic [WIDTH-1:0] q_fwd;
    logic [WIDTH-1:0] q_rev;
    int               ones;
    int               phase_i;

    // A legal Johnson word has at most one boundary between adjacent bits.
    assign edges = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    assign valid = ($countones(edges) <= 1);

    assign q_fwd = {q[WIDTH-2:0], ~q[WIDTH-1]};
    assign q_rev = {~q[0], q[WIDTH-1:1]};

    // Phase decode: ones anchored at bit 0 give phase = popcount; ones anchored at the MSB give 2*WIDTH - popcount.
    always_comb begin
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(q[i]);
        end
        phase_i = 0;
        if (valid) begin
            if (q[0]) begin
                phase_i = ones;
            end else if (ones != 0) begin
                phase_i = 2 * WIDTH - ones;
            end
        end
        phase = PW'(phase_i);
    end

    // State, wrap pulse and sticky error: load beats correction beats step beats hold.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q   <= '0;
            tc  <= 1'b0;
            err <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                q <= load_val;
            end else if (!valid) begin
                q <= '0;
            end else if (en) begin
                if (dir) begin
                    q  <= q_fwd;
                    tc <= (q == LAST_FWD);
                end else begin
                    q  <= q_rev;
                    tc <= (q == '0);
                end
            end
            if (!load && !valid) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_johnson_counter_param.sv
// tb/tb_johnson_counter_param.sv - scoreboard bench for johnson_counter_param
module tb_johnson_counter_param;

    typedef struct packed {
        logic [3:0] q;
        logic [2:0] phase;
        logic       valid;
        logic       tc;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b1;

    logic       en = 1'b0, dir = 1'b1, load = 1'b0, err_clr = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic [3:0] q4;
    logic [2:0] phase4;
    logic       valid4, tc4, err4;

    logic       en2 = 1'b0, dir2 = 1'b1;
    logic [1:0] q2;
    logic [1:0] phase2;
    logic       valid2, tc2, err2;

    logic        en16 = 1'b0, dir16 = 1'b1;
    logic [15:0] q16;
    logic [4:0]  phase16;
    logic        valid16, tc16, err16;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    johnson_counter_param #(.WIDTH(4)) u4 (
        .clk(clk), .clr_n(clr_n), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .err_clr(err_clr), .q(q4), .phase(phase4),
        .valid(valid4), .tc(tc4), .err(err4)
    );

    johnson_counter_param #(.WIDTH(2)) u2 (
        .clk(clk), .clr_n(clr_n), .en(en2), .dir(dir2), .load(1'b0),
        .load_val(2'b00), .err_clr(1'b0), .q(q2), .phase(phase2),
        .valid(valid2), .tc(tc2), .err(err2)
    );

    johnson_counter_param #(.WIDTH(16)) u16 (
        .clk(clk), .clr_n(clr_n), .en(en16), .dir(dir16), .load(1'b0),
        .load_val(16'h0000), .err_clr(1'b0), .q(q16), .phase(phase16),
        .valid(valid16), .tc(tc16), .err(err16)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the W=4 counter presents a result after every edge; compare it with the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q",     int'(q4),     int'(e.q));
            check("phase", int'(phase4), int'(e.phase));
            check("valid", int'(valid4), int'(e.valid));
            check("tc",    int'(tc4),    int'(e.tc));
            check("err",   int'(err4),   int'(e.err));
        end
    end

    task automatic step(input logic e, input logic d, input logic ld, input logic [3:0] lv,
                        input logic ec, input logic [3:0] xq, input logic [2:0] xp,
                        input logic xv, input logic xtc, input logic xerr);
        exp_t x;
        @(negedge clk);
        en = e; dir = d; load = ld; load_val = lv; err_clr = ec;
        x.q = xq; x.phase = xp; x.valid = xv; x.tc = xtc; x.err = xerr;
        sb.push_back(x);
    endtask

    task automatic drain();
        int budget;
        @(negedge clk);
        en = 1'b0; load = 1'b0; err_clr = 1'b0;
        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic mid_reset();
        drain();
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        check("rst_q",   int'(q4),   0);
        check("rst_tc",  int'(tc4),  0);
        check("rst_err", int'(err4), 0);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        int tcc;
        #2;
        clr_n = 1'b0;
        #1;
        check("init_q",     int'(q4),     0);
        check("init_phase", int'(phase4), 0);
        check("init_valid", int'(valid4), 1);
        check("init_tc",    int'(tc4),    0);
        check("init_err",   int'(err4),   0);
        @(negedge clk);
        clr_n = 1'b1;

        // Forward full cycle plus one
        step(1,1,0,4'b0000,0, 4'b0001,3'd1,1,0,0);
        step(1,1,0,4'b0000,0, 4'b0011,3'd2,1,0,0);
        step(1,1,0,4'b0000,0, 4'b0111,3'd3,1,0,0);
        step(1,1,0,4'b0000,0, 4'b1111,3'd4,1,0,0);
        step(1,1,0,4'b0000,0, 4'b1110,3'd5,1,0,0);
        step(1,1,0,4'b0000,0, 4'b1100,3'd6,1,0,0);
        step(1,1,0,4'b0000,0, 4'b1000,3'd7,1,0,0);
        step(1,1,0,4'b0000,0, 4'b0000,3'd0,1,1,0);
        step(1,1,0,4'b0000,0, 4'b0001,3'd1,1,0,0);
        mid_reset();

        // Reverse from reset wraps immediately
        step(1,0,0,4'b0000,0, 4'b1000,3'd7,1,1,0);
        step(1,0,0,4'b0000,0, 4'b1100,3'd6,1,0,0);
        mid_reset();

        // Count, hold, load a legal pattern with en low
        step(1,1,0,4'b0000,0, 4'b0001,3'd1,1,0,0);
        step(1,1,0,4'b0000,0, 4'b0011,3'd2,1,0,0);
        step(1,1,0,4'b0000,0, 4'b0111,3'd3,1,0,0);
        step(0,1,0,4'b0000,0, 4'b0111,3'd3,1,0,0);
        step(0,1,0,4'b0000,0, 4'b0111,3'd3,1,0,0);
        step(0,1,0,4'b0000,0, 4'b0111,3'd3,1,0,0);
        step(0,1,1,4'b1110,0, 4'b1110,3'd5,1,0,0);

        // Illegal load, correction with en low, err clear, then set-wins on same edge
        step(0,1,1,4'b0101,0, 4'b0101,3'd0,0,0,0);
        step(0,1,0,4'b0000,0, 4'b0000,3'd0,1,0,1);
        step(0,1,0,4'b0000,1, 4'b0000,3'd0,1,0,0);
        step(0,1,1,4'b0101,0, 4'b0101,3'd0,0,0,0);
        step(0,1,0,4'b0000,1, 4'b0000,3'd0,1,0,1);

        // Correction takes priority over a step
        step(1,1,1,4'b0101,0, 4'b0101,3'd0,0,0,1);
        step(1,1,0,4'b0000,0, 4'b0000,3'd0,1,0,1);

        // Count to 1100 with err set, then asynchronous reset mid-count
        step(1,1,0,4'b0000,0, 4'b0001,3'd1,1,0,1);
        step(1,1,0,4'b0000,0, 4'b0011,3'd2,1,0,1);
        step(1,1,0,4'b0000,0, 4'b0111,3'd3,1,0,1);
        step(1,1,0,4'b0000,0, 4'b1111,3'd4,1,0,1);
        step(1,1,0,4'b0000,0, 4'b1110,3'd5,1,0,1);
        step(1,1,0,4'b0000,0, 4'b1100,3'd6,1,0,1);
        mid_reset();

        // Resume, then reverse with no turnaround bubble
        step(1,1,0,4'b0000,0, 4'b0001,3'd1,1,0,0);
        step(1,0,0,4'b0000,0, 4'b0000,3'd0,1,0,0);
        step(1,0,0,4'b0000,0, 4'b1000,3'd7,1,1,0);
        drain();

        // WIDTH=2: 4-edge period, one tc each direction
        @(negedge clk);
        en2 = 1'b1; dir2 = 1'b1;
        tcc = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (tc2) tcc++;
            if (i == 1) check("w2_phase_fwd", int'(phase2), 2);
        end
        check("w2_fwd_tc_count", tcc, 1);
        check("w2_fwd_q", int'(q2), 0);
        dir2 = 1'b0;
        tcc = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (tc2) tcc++;
            if (i == 0) check("w2_phase_rev", int'(phase2), 3);
        end
        en2 = 1'b0;
        check("w2_rev_tc_count", tcc, 1);
        check("w2_rev_q", int'(q2), 0);

        // WIDTH=16: 32-edge period, one tc each direction
        @(negedge clk);
        en16 = 1'b1; dir16 = 1'b1;
        tcc = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            if (tc16) tcc++;
            if (i == 15) check("w16_phase16", int'(phase16), 16);
            if (i == 16) check("w16_q17", int'(q16), 32'hFFFE);
        end
        check("w16_fwd_tc_count", tcc, 1);
        check("w16_fwd_q", int'(q16), 0);
        dir16 = 1'b0;
        tcc = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            if (tc16) tcc++;
            if (i == 0) check("w16_phase31", int'(phase16), 31);
        end
        en16 = 1'b0;
        check("w16_rev_tc_count", tcc, 1);
        check("w16_rev_q", int'(q16), 0);
        check("w16_err", int'(err16), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
